// File: rtl/fmdll_pkg.sv
// Shared types and helpers for the FMDLL lock monitor.
package fmdll_pkg;

   typedef enum logic {
      SYNC = 1'b0,
      MEAS = 1'b1
   } mon_state_t;

   localparam int CNT_W_DEF    = 8;
   localparam int LOCK_CNT_DEF = 4;
   localparam int TOL_DEF      = 1;

   // Window length in reference periods; an M of 0 selects the longest window.
   function automatic logic [2:0] win_len(input logic [1:0] m);
      return (m == 2'd0) ? 3'd4 : {1'b0, m};
   endfunction

endpackage

// File: rtl/fmdll_lock_monitor_sync.sv
// Brings clk_ext into the clk_out domain and flags its rising edges.
module clk_ext_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic ext_i,
   output logic ext_lvl_o,
   output logic ext_rise_o
);

   logic s1_q;
   logic s2_q;
   logic hist_q;

   // Two synchronizer flops followed by a history flop for edge detection.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         hist_q <= 1'b0;
      end else begin
         s1_q   <= ext_i;
         s2_q   <= s1_q;
         hist_q <= s2_q;
      end
   end

   assign ext_lvl_o  = s2_q;
   assign ext_rise_o = s2_q & ~hist_q;

endmodule

// File: rtl/fmdll_lock_monitor.sv
// Lock monitor: counts clk_out cycles across M reference periods and
// compares the result against N to derive lock, error and stall status.
//
// state | meaning
// ------+-----------------------------------------------------------------
// SYNC  | idle; waiting for a reference edge to open the first window
// MEAS  | window open; counting clk_out cycles and reference edges
module fmdll_lock_monitor
   import fmdll_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int LOCK_CNT = LOCK_CNT_DEF,
   parameter int TOL      = TOL_DEF
) (
   input  logic             clk_out,
   input  logic             rst_n,
   input  logic             clk_ext,
   input  logic [1:0]       M,
   input  logic [3:0]       N,
   output logic [CNT_W-1:0] meas,
   output logic             meas_valid,
   output logic             lock,
   output logic             err,
   output logic             stall
);

   localparam int               STRK_W  = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] CYC_MAX = '1;

   mon_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cyc_q, cyc_d;
   logic [2:0]        edg_q, edg_d;
   logic [STRK_W-1:0] strk_q, strk_d;
   logic [1:0]        m_q;
   logic [3:0]        n_q;
   logic [CNT_W-1:0]  meas_q, meas_d;
   logic              mv_q, mv_d;
   logic              lock_q, lock_d;
   logic              err_q, err_d;
   logic              stall_q, stall_d;

   logic              ext_lvl;
   logic              ext_rise;
   logic              rise;
   logic              cfg_chg;
   logic [2:0]        edg_inc;
   logic              closing;
   logic signed [CNT_W:0] diff;
   logic [CNT_W:0]    abs_diff;
   logic              match;
   logic [STRK_W-1:0] strk_inc;

   clk_ext_sync u_sync (
      .clk_i      (clk_out),
      .rst_ni     (rst_n),
      .ext_i      (clk_ext),
      .ext_lvl_o  (ext_lvl),
      .ext_rise_o (ext_rise)
   );

   // An edge is only accepted while the synchronized level is high.
   assign rise     = ext_rise & ext_lvl;
   assign cfg_chg  = (M != m_q) || (N != n_q);
   assign edg_inc  = edg_q + 3'd1;
   assign closing  = rise && (edg_inc == win_len(m_q));
   assign strk_inc = (strk_q == STRK_W'(LOCK_CNT)) ? strk_q : strk_q + 1'b1;

   // Signed comparison of the finished window count against the target.
   always_comb begin
      diff     = $signed({1'b0, cyc_q}) - $signed({{(CNT_W-3){1'b0}}, n_q});
      abs_diff = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
      match    = (n_q != 4'd0) && (abs_diff <= (CNT_W+1)'(TOL));
   end

   // Next-state, counter and status logic.
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      edg_d   = edg_q;
      strk_d  = strk_q;
      meas_d  = meas_q;
      mv_d    = 1'b0;
      err_d   = 1'b0;
      lock_d  = lock_q;
      stall_d = stall_q;

      if (cfg_chg) begin
         // A config change invalidates whatever window was in flight.
         state_d = SYNC;
         cyc_d   = '0;
         edg_d   = 3'd0;
         strk_d  = '0;
         lock_d  = 1'b0;
      end else begin
         case (state_q)
            SYNC: begin
               if (rise) begin
                  cyc_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                  edg_d   = 3'd0;
                  state_d = MEAS;
               end
            end
            MEAS: begin
               if (closing) begin
                  // The closing edge also opens the next window.
                  meas_d  = cyc_q;
                  mv_d    = 1'b1;
                  stall_d = 1'b0;
                  cyc_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                  edg_d   = 3'd0;
                  if (match) begin
                     strk_d = strk_inc;
                     lock_d = lock_q | (strk_inc == STRK_W'(LOCK_CNT));
                  end else begin
                     err_d  = 1'b1;
                     strk_d = '0;
                     lock_d = 1'b0;
                  end
               end else if (cyc_q == CYC_MAX) begin
                  stall_d = 1'b1;
                  meas_d  = CYC_MAX;
                  mv_d    = 1'b1;
                  err_d   = 1'b1;
                  strk_d  = '0;
                  lock_d  = 1'b0;
                  cyc_d   = '0;
                  edg_d   = 3'd0;
                  state_d = SYNC;
               end else begin
                  cyc_d = cyc_q + 1'b1;
                  if (rise) begin
                     edg_d = edg_inc;
                  end
               end
            end
            default: state_d = SYNC;
         endcase
      end
   end

   // State, counters, registered config and registered outputs.
   always_ff @(posedge clk_out or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SYNC;
         cyc_q   <= '0;
         edg_q   <= 3'd0;
         strk_q  <= '0;
         m_q     <= 2'd0;
         n_q     <= 4'd0;
         meas_q  <= '0;
         mv_q    <= 1'b0;
         lock_q  <= 1'b0;
         err_q   <= 1'b0;
         stall_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         edg_q   <= edg_d;
         strk_q  <= strk_d;
         m_q     <= M;
         n_q     <= N;
         meas_q  <= meas_d;
         mv_q    <= mv_d;
         lock_q  <= lock_d;
         err_q   <= err_d;
         stall_q <= stall_d;
      end
   end

   assign meas       = meas_q;
   assign meas_valid = mv_q;
   assign lock       = lock_q;
   assign err        = err_q;
   assign stall      = stall_q;

endmodule

// File: tb/tb_fmdll_lock_monitor.sv
// Randomized bench for fmdll_lock_monitor with a timestamp-based reference model.
module tb_fmdll_lock_monitor;

   logic       clk_out = 1'b0;
   logic       rst_n   = 1'b0;
   logic       clk_ext = 1'b0;
   logic [1:0] M       = 2'd0;
   logic [3:0] N       = 4'd0;
   logic [7:0] meas;
   logic       meas_valid;
   logic       lock;
   logic       err;
   logic       stall;

   int checks = 0;
   int errors = 0;

   always #5 clk_out = ~clk_out;

   fmdll_lock_monitor dut (
      .clk_out    (clk_out),
      .rst_n      (rst_n),
      .clk_ext    (clk_ext),
      .M          (M),
      .N          (N),
      .meas       (meas),
      .meas_valid (meas_valid),
      .lock       (lock),
      .err        (err),
      .stall      (stall)
   );

   // Stimulus settings
   int cur_m = 1;
   int cur_n = 8;
   int chg_cd = 0;
   int chg_n = 0;

   // Reference model: reference samples per edge, window open timestamp,
   // edge count, match streak and the expected outputs.
   bit h1, h2, h3;
   int pm, pn;
   bit in_win;
   int k, t0, edges, streak;
   bit e_lock, e_stall, e_mv, e_err;
   int e_meas;

   function automatic int wlen(int m);
      return (m == 0) ? 4 : m;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, int expv);
      checks++;
      assert (obs === 32'(expv)) else begin
         errors++;
         $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, k, obs, expv);
      end
   endtask

   task automatic model_reset();
      h1 = 0; h2 = 0; h3 = 0;
      pm = 0; pn = 0;
      in_win = 0; k = 0; t0 = 0; edges = 0; streak = 0;
      e_lock = 0; e_stall = 0; e_mv = 0; e_err = 0; e_meas = 0;
   endtask

   task automatic model_edge(bit x, int m, int n);
      bit rise;
      bit cfg;
      int elapsed;
      int d;
      rise = h2 && !h3;
      cfg  = (m != pm) || (n != pn);
      k++;
      e_mv = 0;
      e_err = 0;
      if (cfg) begin
         in_win = 0; streak = 0; e_lock = 0;
      end else if (!in_win) begin
         if (rise) begin
            in_win = 1; t0 = k; edges = 0;
         end
      end else begin
         elapsed = k - t0;
         if (rise && (edges + 1 == wlen(pm))) begin
            e_meas = elapsed; e_mv = 1; e_stall = 0;
            d = elapsed - pn;
            if (d < 0) d = -d;
            if (pn != 0 && d <= 1) begin
               if (streak < 4) streak++;
               if (streak == 4) e_lock = 1;
            end else begin
               e_err = 1; streak = 0; e_lock = 0;
            end
            t0 = k; edges = 0;
         end else if (elapsed == 255) begin
            e_stall = 1; e_meas = 255; e_mv = 1; e_err = 1;
            e_lock = 0; streak = 0; in_win = 0;
         end else if (rise) begin
            edges++;
         end
      end
      h3 = h2; h2 = h1; h1 = x;
      pm = m; pn = n;
   endtask

   task automatic check_outputs();
      chk("meas", {24'd0, meas}, e_meas);
      chk("meas_valid", {31'd0, meas_valid}, int'(e_mv));
      chk("err", {31'd0, err}, int'(e_err));
      chk("lock", {31'd0, lock}, int'(e_lock));
      chk("stall", {31'd0, stall}, int'(e_stall));
   endtask

   task automatic step(bit x);
      @(negedge clk_out);
      if (chg_cd > 0) begin
         chg_cd--;
         if (chg_cd == 0) cur_n = chg_n;
      end
      clk_ext = x;
      M = 2'(cur_m);
      N = 4'(cur_n);
      @(posedge clk_out);
      model_edge(x, cur_m, cur_n);
      #1;
      check_outputs();
   endtask

   task automatic run_wave(int period, int jit, int nrise);
      int prev_j;
      int j;
      int gap;
      prev_j = 0;
      for (int i = 0; i < nrise; i++) begin
         j = (jit > 0) ? int'($urandom_range(0, 2 * jit)) - jit : 0;
         gap = period + j - prev_j;
         prev_j = j;
         for (int c = 0; c < gap; c++) step(c < gap / 2);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_out);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      repeat (3) @(negedge clk_out);
      check_outputs();
      rst_n = 1'b1;
   endtask

   initial begin
      int per;
      int nr;
      model_reset();
      #2;
      check_outputs();
      @(negedge clk_out);
      rst_n = 1'b1;

      // Clean 8-cycle reference, N=8, M=1
      cur_m = 1; cur_n = 8;
      run_wave(8, 0, 8);
      chk("lock_after_clean_run", {31'd0, lock}, 1);

      // Reference slows to 10 cycles while locked
      run_wave(10, 0, 3);
      chk("lock_after_slow_ref", {31'd0, lock}, 0);

      // Relock, then stop the reference
      run_wave(8, 0, 7);
      for (int i = 0; i < 300; i++) step(1'b0);
      chk("stall_after_hold", {31'd0, stall}, 1);
      chk("meas_after_hold", {24'd0, meas}, 255);
      run_wave(8, 0, 4);
      chk("stall_cleared", {31'd0, stall}, 0);

      // Target changes to 9 while locked
      run_wave(8, 0, 6);
      cur_n = 9;
      run_wave(9, 0, 7);
      run_wave(10, 0, 6);

      // N=12, M=3 with a 4-cycle reference and +/-1 edge jitter
      cur_m = 3; cur_n = 12;
      run_wave(4, 1, 30);

      // M=0 selects 4 periods
      cur_m = 0; cur_n = 12;
      run_wave(3, 0, 24);

      // Reset in the middle of a window
      cur_m = 1; cur_n = 8;
      run_wave(8, 0, 3);
      for (int c = 0; c < 5; c++) step(c < 4);
      do_reset();
      run_wave(8, 0, 6);

      // N=0 is never a match
      cur_n = 0;
      run_wave(8, 0, 8);
      chk("lock_with_n0", {31'd0, lock}, 0);

      // Random configurations, some changed mid-window
      for (int it = 0; it < 30; it++) begin
         cur_m = int'($urandom_range(0, 3));
         cur_n = int'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1)
            per = (cur_n / wlen(cur_m) < 3) ? 3 : cur_n / wlen(cur_m);
         else
            per = int'($urandom_range(3, 10));
         if ($urandom_range(0, 2) == 0) begin
            chg_cd = int'($urandom_range(5, 60));
            chg_n = int'($urandom_range(1, 15));
         end
         nr = 4 * wlen(cur_m) + int'($urandom_range(0, 6));
         run_wave(per, int'($urandom_range(0, 1)), nr);
         chg_cd = 0;
         if ($urandom_range(0, 9) == 0) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
